wb_dma_8bit: RTL and testbench
==============================

// Module: wb_dma_8bit
// PURPOSE
//  Wishbone initiator (bus master) on the 8-bit data / 11-bit address Wishbone segment used by wb_ram_8x2k.
//  Copies a block of LEN bytes from SRC to DST, one byte at a time: a single read, then a single write.
//  Started from a simple command port (CPU register block or test sequencer).
//  Reports completion and bus timeout.
// PARAMETERS
//  AW       11  Wishbone address width (bytes)
//  DW       8   Wishbone data width
//  TIMEOUT  16  max clocks waiting on wb_ack_i (assert or release) before abort; >=2
// PORTS
//  clk_i        in   1     clock, all logic on rising edge
//  rst_n_i      in   1     synchronous reset, active-low
//  start_i      in   1     command strobe, sampled only in IDLE
//  src_addr_i   in   AW    first source byte address
//  dst_addr_i   in   AW    first destination byte address
//  len_i        in   AW+1  byte count, 0..2**AW
//  busy_o       out  1     transfer in progress
//  done_o       out  1     one-clock pulse at end of transfer (normal or aborted)
//  err_o        out  1     sticky timeout flag; cleared by next accepted start
//  wb_addr_o    out  AW    Wishbone address
//  wb_data_o    out  DW    Wishbone write data
//  wb_data_i    in   DW    Wishbone read data
//  wb_we_o      out  1     write enable
//  wb_cyc_o     out  1     cycle
//  wb_stb_o     out  1     strobe
//  wb_sel_o     out  1     byte select
//  wb_ack_i     in   1     slave acknowledge
// BEHAVIOUR
//  Reset (rst_n_i=0 at an edge) takes effect the next cycle, including mid-transfer:
//   - all outputs 0, state IDLE, err_o 0.
//   - The bus is released immediately; no done_o.
//  States: IDLE, RD, RD_GAP, WR, WR_GAP, ERR, DONE.
//  IDLE
//   - start_i=1: latch src, dst, len; clear err_o and byte counter cnt; go RD (len=0 -> go DONE).
//   - start_i outside IDLE is ignored.
//  RD
//   - Drives cyc=stb=sel=1, we=0, addr=src+cnt (mod 2**AW).
//   - On wb_ack_i=1: capture wb_data_i into rd_byte; go RD_GAP.
//  RD_GAP
//   - cyc=stb=sel=0; wait for wb_ack_i=0, then go WR.
//   - Required because the slave holds ack until sel drops.
//  WR
//   - Drives cyc=stb=sel=we=1, addr=dst+cnt (mod 2**AW), data=rd_byte.
//   - On ack: go WR_GAP.
//  WR_GAP
//   - Strobes low; on wb_ack_i=0: cnt<=cnt+1.
//   - Then go DONE if cnt+1==len, else go RD.
//  Timeout
//   - tcnt resets on every state entry and counts clocks in RD, RD_GAP, WR, WR_GAP.
//   - At tcnt==TIMEOUT-1 without the awaited ack edge: go ERR.
//  ERR: strobes low, err_o<=1, go DONE.
//  DONE: done_o=1 for one clock, then IDLE.
//  busy_o=1 in every state except IDLE.
//  Bus outputs are registered. wb_addr_o and wb_data_o are held stable while stb is high. we=0 whenever cyc=0.
//  Cycle count against the zero-wait slave (ack 1 clk after stb, release 1 clk after sel drop):
//   - 4 clocks per bus access, 8 per byte.
//   - busy_o high exactly 8*len+1 clocks.
//  Address wrap: src+cnt and dst+cnt wrap modulo 2**AW with no error.
//  Overlapping src/dst: strictly ascending byte order; no overlap handling.
//  ack_i arriving in IDLE, DONE or ERR is ignored.
// STRUCTURE
//  wb_dma_defines.v (shared include)
//   - state encodings as localparams.
//   - default AW, DW, TIMEOUT.
//  Sub-module wb_timeout_cnt
//   - Inputs: clear, enable.
//   - Output: expired pulse.
//   - Parameter TIMEOUT; counter width $clog2(TIMEOUT).
//   - Reused by other bus masters.
//  FSM, address adders and data register in this file.
// TESTING (bench: this master + wb_ram_8x2k generic model)
//  1. Preload RAM[0..3]=11,22,33,44; start src=0 dst=0x100 len=4.
//     Expect: RAM[0x100..0x103]=11,22,33,44; busy_o 33 clks; one done_o; err_o=0.
//  2. len=0. Expect: busy_o 1 clk, done_o pulse, no cyc_o ever asserted.
//  3. src=0x7FE dst=0x010 len=4 with RAM[0x7FE,0x7FF,0,1]=A,B,C,D.
//     Expect: RAM[0x10..0x13]=A,B,C,D (address wrap).
//  4. Replace slave with stub that never acks; start len=2.
//     Expect: after 16 clks in RD, strobes drop, err_o=1, done_o pulse.
//     err_o stays 1 until next start.
//  5. Assert rst_n_i=0 for 1 clk mid-WR of byte 2 of len=8.
//     Expect: next cycle cyc/stb/busy/done=0, state IDLE.
//     A new start then copies correctly.
//  6. Pulse start_i while busy with different src.
//     Expect: ignored, original transfer completes unchanged.
//     Protocol checker: stb never high with cyc low; no new stb while ack_i high.

Source files
------------

// File: rtl/wb_dma_8bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_dma_8bit_pkg
// Description : Shared definitions for the 8-bit Wishbone DMA master:
//               default bus geometry, timeout length and FSM state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package wb_dma_8bit_pkg;

  localparam int DEF_AW      = 11;
  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RD_GAP = 3'd2,
    ST_WR     = 3'd3,
    ST_WR_GAP = 3'd4,
    ST_ERR    = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // States in which the master is waiting on an ack edge and the
  // timeout counter must run.
  function automatic logic is_bus_state(input state_e s);
    return (s == ST_RD) || (s == ST_RD_GAP) || (s == ST_WR) || (s == ST_WR_GAP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_dma_8bit_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_dma_8bit_if
// Description : Single-byte Wishbone segment. Signal names are seen from the
//               master side (_o driven by master, _i driven by slave).
//   wb_addr_o  AW  address          wb_data_o  DW  write data
//   wb_data_i  DW  read data        wb_we_o     1  write enable
//   wb_cyc_o    1  cycle            wb_stb_o    1  strobe
//   wb_sel_o    1  byte select      wb_ack_i    1  acknowledge
// Revision    : 1.0  initial release
// ============================================================================
interface wb_dma_8bit_if
  import wb_dma_8bit_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_data_o;
  logic [DW-1:0] wb_data_i;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_sel_o;
  logic          wb_ack_i;

  modport master (
    output wb_addr_o, wb_data_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o,
    input  wb_data_i, wb_ack_i
  );

  modport slave (
    input  wb_addr_o, wb_data_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o,
    output wb_data_i, wb_ack_i
  );

endinterface
`default_nettype wire

// File: rtl/wb_dma_8bit_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_cnt
// Description : Generic bus-wait watchdog. Counts enabled clocks since the
//               last clear and flags the clock on which the count reaches
//               TIMEOUT-1.
//   clk_i      in   clock
//   rst_n_i    in   synchronous active-low reset
//   clear_i    in   restart count at 0 on the next clock
//   enable_i   in   count this clock
//   expired_o  out  count is at TIMEOUT-1 while enabled
// Revision    : 1.0  initial release
// ============================================================================
module wb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  wire logic clk_i,
  input  wire logic rst_n_i,
  input  wire logic clear_i,
  input  wire logic enable_i,
  output logic      expired_o
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST so a master that ignores expiry cannot see the count
  // wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Not gated by clear_i: the owner derives clear from its next state,
  // which itself depends on this flag.
  assign expired_o = enable_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/wb_dma_8bit.sv
`default_nettype none
// ============================================================================
// Module      : wb_dma_8bit
// Description : Byte-wide Wishbone copy engine. Moves len_i bytes from
//               src_addr_i to dst_addr_i as alternating single reads and
//               writes, with a per-state ack watchdog.
//   clk_i       in   clock
//   rst_n_i     in   synchronous active-low reset
//   start_i     in   command strobe, honoured only when idle
//   src_addr_i  in   first source address
//   dst_addr_i  in   first destination address
//   len_i       in   byte count 0..2**AW
//   busy_o      out  transfer in progress
//   done_o      out  one-clock end-of-transfer pulse
//   err_o       out  sticky timeout flag
//   wb          --   Wishbone master port
// Revision    : 1.0  initial release
// ============================================================================
module wb_dma_8bit
  import wb_dma_8bit_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  wire logic          clk_i,
  input  wire logic          rst_n_i,
  input  wire logic          start_i,
  input  wire logic [AW-1:0] src_addr_i,
  input  wire logic [AW-1:0] dst_addr_i,
  input  wire logic [AW:0]   len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  wb_dma_8bit_if.master      wb
);

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   cnt_inc;
  logic [DW-1:0] rd_byte_q, rd_byte_d;
  logic          err_q, err_d;

  // Registered bus outputs; cyc, stb and sel always move together.
  logic [AW-1:0] addr_q, addr_d;
  logic          strb_q, strb_d;
  logic          we_q, we_d;

  logic          tmo_clear;
  logic          tmo_enable;
  logic          tmo_expired;

  assign cnt_inc = cnt_q + (AW+1)'(1);

  // The watchdog restarts on every state change, so each ack edge gets a
  // full TIMEOUT window of its own.
  assign tmo_clear  = (state_d != state_q);
  assign tmo_enable = is_bus_state(state_q);

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rd_byte_d = rd_byte_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          len_d   = len_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (len_i == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        if (wb.wb_ack_i) begin
          rd_byte_d = wb.wb_data_i;
          state_d   = ST_RD_GAP;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end
      end
      // The slave keeps ack high until it sees sel drop; wait for the
      // release before strobing again.
      ST_RD_GAP: begin
        if (!wb.wb_ack_i) begin
          state_d = ST_WR;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_WR: begin
        if (wb.wb_ack_i) begin
          state_d = ST_WR_GAP;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_WR_GAP: begin
        if (!wb.wb_ack_i) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? ST_DONE : ST_RD;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from the next state so they are registered yet
  // line up with the state they belong to. Address only changes on entry
  // to a strobing state, so it is stable while stb is high.
  always_comb begin
    addr_d = addr_q;
    strb_d = (state_d == ST_RD) || (state_d == ST_WR);
    we_d   = (state_d == ST_WR);
    if (state_d == ST_RD) begin
      addr_d = src_d + cnt_d[AW-1:0];
    end else if (state_d == ST_WR) begin
      addr_d = dst_d + cnt_d[AW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rd_byte_q <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      strb_q    <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rd_byte_q <= rd_byte_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      strb_q    <= strb_d;
      we_q      <= we_d;
    end
  end

  assign wb.wb_addr_o = addr_q;
  assign wb.wb_data_o = rd_byte_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_cyc_o  = strb_q;
  assign wb.wb_stb_o  = strb_q;
  assign wb.wb_sel_o  = strb_q;

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_dma_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_dma_8bit
// Description : Directed bench for wb_dma_8bit with a zero-wait 2 KB byte RAM
//               slave (ack one clock after strobe, held until sel drops).
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_dma_8bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] src;
  logic [10:0] dst;
  logic [11:0] len;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks;
  int n_err;

  wb_dma_8bit_if #(.AW(11), .DW(8)) bus ();

  wb_dma_8bit #(
    .AW      (11),
    .DW      (8),
    .TIMEOUT (16)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .src_addr_i (src),
    .dst_addr_i (dst),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .wb         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM slave model ----------------
  logic [7:0]  mem [0:2047];
  logic        ack_en;
  logic        ack;
  logic [7:0]  rdata;
  logic        pl_en;
  logic [10:0] pl_addr;
  logic [7:0]  pl_data;

  always @(posedge clk) begin
    if (!rst_n) ack <= 1'b0;
    else        ack <= bus.wb_cyc_o & bus.wb_stb_o & bus.wb_sel_o & ack_en;
    rdata <= mem[bus.wb_addr_o];
    if (ack_en & bus.wb_cyc_o & bus.wb_stb_o & bus.wb_sel_o & bus.wb_we_o)
      mem[bus.wb_addr_o] <= bus.wb_data_o;
    if (pl_en)
      mem[pl_addr] <= pl_data;
  end

  assign bus.wb_ack_i  = ack;
  assign bus.wb_data_i = rdata;

  // ---------------- monitors / protocol checker ----------------
  int   busy_tot, done_tot, stb_tot, cyc_tot, proto_err;
  logic stb_prev;

  initial begin
    busy_tot = 0; done_tot = 0; stb_tot = 0; cyc_tot = 0; proto_err = 0;
    stb_prev = 1'b0;
  end

  always @(negedge clk) begin
    busy_tot <= busy_tot + int'(busy);
    done_tot <= done_tot + int'(done);
    stb_tot  <= stb_tot + int'(bus.wb_stb_o);
    cyc_tot  <= cyc_tot + int'(bus.wb_cyc_o);
    if (bus.wb_stb_o && !bus.wb_cyc_o)               proto_err <= proto_err + 1;
    else if (bus.wb_stb_o && !stb_prev && bus.wb_ack_i) proto_err <= proto_err + 1;
    stb_prev <= bus.wb_stb_o;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [10:0] s, input logic [10:0] d, input logic [11:0] l);
    src = s; dst = d; len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
    repeat (3) tick();
  endtask

  int b0, d0, c0, s0;
  logic found;

  initial begin
    n_checks = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    ack_en = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) tick();

    // Reset state
    check("reset_outputs", {26'd0, busy, done, err, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic 4-byte copy
    preload(11'h000, 8'h11); preload(11'h001, 8'h22);
    preload(11'h002, 8'h33); preload(11'h003, 8'h44);
    for (int i = 0; i < 4; i++) preload(11'h100 + 11'(i), 8'h00);
    b0 = busy_tot; d0 = done_tot;
    pulse_start(11'h000, 11'h100, 12'd4);
    wait_done("t1_done_seen", 80);
    check("t1_busy_clks", busy_tot - b0, 32'd33);
    check("t1_done_pulses", done_tot - d0, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_ram100", {24'd0, mem[11'h100]}, 32'h11);
    check("t1_ram101", {24'd0, mem[11'h101]}, 32'h22);
    check("t1_ram102", {24'd0, mem[11'h102]}, 32'h33);
    check("t1_ram103", {24'd0, mem[11'h103]}, 32'h44);

    // 2: zero-length command
    b0 = busy_tot; d0 = done_tot; c0 = cyc_tot;
    pulse_start(11'h000, 11'h100, 12'd0);
    wait_done("t2_done_seen", 10);
    check("t2_busy_clks", busy_tot - b0, 32'd1);
    check("t2_done_pulses", done_tot - d0, 32'd1);
    check("t2_cyc_clks", cyc_tot - c0, 32'd0);

    // 3: source address wraps past the top of the space
    preload(11'h7FE, 8'hA1); preload(11'h7FF, 8'hB2);
    preload(11'h000, 8'hC3); preload(11'h001, 8'hD4);
    for (int i = 0; i < 4; i++) preload(11'h010 + 11'(i), 8'h00);
    b0 = busy_tot;
    pulse_start(11'h7FE, 11'h010, 12'd4);
    wait_done("t3_done_seen", 80);
    check("t3_busy_clks", busy_tot - b0, 32'd33);
    check("t3_ram010", {24'd0, mem[11'h010]}, 32'hA1);
    check("t3_ram011", {24'd0, mem[11'h011]}, 32'hB2);
    check("t3_ram012", {24'd0, mem[11'h012]}, 32'hC3);
    check("t3_ram013", {24'd0, mem[11'h013]}, 32'hD4);

    // 4: slave never acknowledges
    preload(11'h020, 8'h5A); preload(11'h030, 8'h00);
    ack_en = 1'b0;
    b0 = busy_tot; d0 = done_tot; s0 = stb_tot;
    pulse_start(11'h020, 11'h030, 12'd2);
    wait_done("t4_done_seen", 60);
    check("t4_stb_clks", stb_tot - s0, 32'd16);
    check("t4_busy_clks", busy_tot - b0, 32'd18);
    check("t4_done_pulses", done_tot - d0, 32'd1);
    check("t4_err_set", {31'd0, err}, 32'd1);
    check("t4_no_write", {24'd0, mem[11'h030]}, 32'h00);
    repeat (5) tick();
    check("t4_err_sticky", {31'd0, err}, 32'd1);
    ack_en = 1'b1;
    pulse_start(11'h000, 11'h000, 12'd0);
    wait_done("t4_clr_done_seen", 10);
    check("t4_err_cleared", {31'd0, err}, 32'd0);

    // 5: reset during the write of the second byte of an 8-byte copy
    for (int i = 0; i < 8; i++) begin
      preload(11'h040 + 11'(i), 8'h50 + 8'(i));
      preload(11'h500 + 11'(i), 8'h00);
      preload(11'h600 + 11'(i), 8'h00);
    end
    pulse_start(11'h040, 11'h500, 12'd8);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (bus.wb_stb_o && bus.wb_we_o && bus.wb_addr_o == 11'h501) found = 1'b1;
      else tick();
    end
    check("t5_wr2_reached", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_after_reset", {28'd0, bus.wb_cyc_o, bus.wb_stb_o, busy, done}, 32'd0);
    d0 = done_tot;
    repeat (20) tick();
    check("t5_no_done", done_tot - d0, 32'd0);
    check("t5_no_byte3", {24'd0, mem[11'h502]}, 32'h00);
    b0 = busy_tot;
    pulse_start(11'h040, 11'h600, 12'd8);
    wait_done("t5_done_seen", 120);
    check("t5_busy_clks", busy_tot - b0, 32'd65);
    for (int i = 0; i < 8; i++)
      check($sformatf("t5_ram6%02h", i), {24'd0, mem[11'h600 + 11'(i)]}, 32'h50 + 32'(i));

    // 6: start pulse while busy is ignored
    preload(11'h080, 8'hC1); preload(11'h081, 8'hC2);
    preload(11'h082, 8'hC3); preload(11'h083, 8'hC4);
    preload(11'h0C0, 8'hEE); preload(11'h710, 8'h00);
    for (int i = 0; i < 4; i++) preload(11'h700 + 11'(i), 8'h00);
    b0 = busy_tot; d0 = done_tot;
    pulse_start(11'h080, 11'h700, 12'd4);
    repeat (5) tick();
    pulse_start(11'h0C0, 11'h710, 12'd1);
    wait_done("t6_done_seen", 80);
    check("t6_busy_clks", busy_tot - b0, 32'd33);
    check("t6_done_pulses", done_tot - d0, 32'd1);
    check("t6_ram700", {24'd0, mem[11'h700]}, 32'hC1);
    check("t6_ram701", {24'd0, mem[11'h701]}, 32'hC2);
    check("t6_ram702", {24'd0, mem[11'h702]}, 32'hC3);
    check("t6_ram703", {24'd0, mem[11'h703]}, 32'hC4);
    check("t6_ram710", {24'd0, mem[11'h710]}, 32'h00);

    check("protocol_violations", proto_err, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
